// File: rtl/ipc_comlink.sv
// ipc_comlink: IPC-side endpoint of the COMCTRL/COMDATA serial link to the ZX8302.
//
// Each bit is exchanged as one host nibble: the host writes S=0, D, E=1 into its
// 4-bit comdata shift register, and this block clocks that register with two
// comctrl low pulses. D is sampled after the first pulse and E after the second.
// When transmitting, the bit being returned to the host is held on comdata_out.
// The host sees that bit through its status read, which is the AND of both
// comdata lines.
//
// Ports:
//   clk_sys      board clock, the only clock
//   reset        synchronous, active-high
//   comctrl      strobe to ZX8302, idle high; a falling edge shifts the host register
//   comdata_in   host bit, asynchronous; synchronised internally by two flops
//   comdata_out  IPC-driven bit, idle high
//   rx_start     one-cycle request to receive rx_len bits
//   tx_start     one-cycle request to send tx_len bits of tx_data, MSB first
//   rx_len       receive bit count, 1..8 (0 means 8)
//   tx_len       transmit bit count, 1..8 (0 means 8)
//   tx_data      bits to send; bit (len-1) goes first
//   rx_data      received word, right-aligned, first bit most significant
//   rx_valid     one-cycle pulse when rx_data is complete
//   tx_done      one-cycle pulse when the last transmitted bit has been released
//   busy         high whenever an operation is in progress
//   err          one-cycle pulse on a timeout or a bad stop bit; the operation is aborted
module ipc_comlink #(
  parameter int unsigned PULSE_LEN = 27,
  parameter int unsigned SETTLE    = 27,
  parameter int unsigned TIMEOUT   = 2700000
) (
  input  logic       clk_sys,
  input  logic       reset,
  output logic       comctrl,
  input  logic       comdata_in,
  output logic       comdata_out,
  input  logic       rx_start,
  input  logic       tx_start,
  input  logic [3:0] rx_len,
  input  logic [3:0] tx_len,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_done,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StLow1,
    StHigh1,
    StLow2,
    StHigh2,
    StHold
  } state_e;

  // Terminal counts; both counters start from zero on every state entry.
  localparam logic [7:0]  PulseLast  = 8'(PULSE_LEN - 1);
  localparam logic [7:0]  SettleLast = 8'(SETTLE - 1);
  localparam logic [21:0] WaitLast   = 22'(TIMEOUT - 1);

  // Length 0 means a full byte; out-of-range lengths are clamped to 8 as well.
  function automatic logic [3:0] bit_count(input logic [3:0] len);
    return ((len == 4'd0) || (len > 4'd8)) ? 4'd8 : len;
  endfunction

  state_e      state_q, state_d;
  logic [21:0] wait_q, wait_d;
  logic [7:0]  phase_q, phase_d;
  logic        cd_meta_q, cd_q;
  logic        tx_mode_q, tx_mode_d;
  logic [3:0]  left_q, left_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        comctrl_q, comctrl_d;
  logic        cdo_q, cdo_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_done_q, tx_done_d;
  logic        err_q, err_d;

  logic [2:0]  tx_first_idx;
  logic [2:0]  tx_next_idx;

  assign tx_first_idx = 3'(bit_count(tx_len) - 4'd1);
  assign tx_next_idx  = 3'(left_q - 4'd1);

  always_comb begin
    state_d    = state_q;
    tx_mode_d  = tx_mode_q;
    left_d     = left_q;
    tx_data_d  = tx_data_q;
    rx_shift_d = rx_shift_q;
    cdo_d      = cdo_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_done_d  = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Receive takes priority; a simultaneous tx_start is dropped.
        if (rx_start) begin
          state_d    = StWaitStart;
          tx_mode_d  = 1'b0;
          left_d     = bit_count(rx_len);
          rx_shift_d = '0;
        end else if (tx_start) begin
          state_d   = StWaitStart;
          tx_mode_d = 1'b1;
          left_d    = bit_count(tx_len);
          tx_data_d = tx_data;
          cdo_d     = tx_data[tx_first_idx];
        end
      end

      StWaitStart: begin
        if (!cd_q) begin
          state_d = StLow1;
        end else if (wait_q == WaitLast) begin
          err_d   = 1'b1;
          cdo_d   = 1'b1;
          state_d = StIdle;
        end
      end

      StLow1: begin
        if (phase_q == PulseLast) state_d = StHigh1;
      end

      StHigh1: begin
        if (phase_q == SettleLast) begin
          state_d = StLow2;
          if (!tx_mode_q) rx_shift_d = {rx_shift_q[6:0], cd_q};
        end
      end

      StLow2: begin
        if (phase_q == PulseLast) state_d = StHigh2;
      end

      StHigh2: begin
        if (phase_q == SettleLast) begin
          if (!cd_q) begin
            // Stop bit must read back as 1.
            err_d   = 1'b1;
            cdo_d   = 1'b1;
            state_d = StIdle;
          end else begin
            left_d = left_q - 4'd1;
            if (tx_mode_q) begin
              state_d = StHold;
            end else if (left_q == 4'd1) begin
              rx_valid_d = 1'b1;
              rx_data_d  = rx_shift_q;
              state_d    = StIdle;
            end else begin
              state_d = StWaitStart;
            end
          end
        end
      end

      StHold: begin
        // The host's next nibble doubles as the start bit for the following bit.
        if (!cd_q) begin
          if (left_q != 4'd0) begin
            state_d = StLow1;
            cdo_d   = tx_data_q[tx_next_idx];
          end else begin
            tx_done_d = 1'b1;
            cdo_d     = 1'b1;
            state_d   = StIdle;
          end
        end else if (wait_q == WaitLast) begin
          cdo_d   = 1'b1;
          state_d = StIdle;
          if (left_q != 4'd0) err_d = 1'b1;
          else                tx_done_d = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Counters reload on every state change and only count in the states that use them.
  always_comb begin
    wait_d  = '0;
    phase_d = '0;
    if (state_d == state_q) begin
      if ((state_q == StWaitStart) || (state_q == StHold)) begin
        wait_d = wait_q + 22'd1;
      end
      if ((state_q == StLow1) || (state_q == StHigh1) ||
          (state_q == StLow2) || (state_q == StHigh2)) begin
        phase_d = phase_q + 8'd1;
      end
    end
  end

  // comctrl is registered from the next state so it cannot glitch.
  assign comctrl_d = !((state_d == StLow1) || (state_d == StLow2));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_q     <= '0;
      phase_q    <= '0;
      cd_meta_q  <= 1'b1;
      cd_q       <= 1'b1;
      tx_mode_q  <= 1'b0;
      left_q     <= '0;
      tx_data_q  <= '0;
      rx_shift_q <= '0;
      comctrl_q  <= 1'b1;
      cdo_q      <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_done_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      phase_q    <= phase_d;
      cd_meta_q  <= comdata_in;
      cd_q       <= cd_meta_q;
      tx_mode_q  <= tx_mode_d;
      left_q     <= left_d;
      tx_data_q  <= tx_data_d;
      rx_shift_q <= rx_shift_d;
      comctrl_q  <= comctrl_d;
      cdo_q      <= cdo_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_done_q  <= tx_done_d;
      err_q      <= err_d;
    end
  end

  assign comctrl     = comctrl_q;
  assign comdata_out = cdo_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_done     = tx_done_q;
  assign err         = err_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_ipc_comlink.sv
// Bench for ipc_comlink: a reactive host shift-register model, a cycle-level
// reference model built from the bit-timing arithmetic, one per-cycle compare
// process, and directed scenarios with hand-computed expectations.
module tb_ipc_comlink;

  localparam int P = 3;
  localparam int S = 2;
  localparam int T = 100;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       comctrl;
  logic       comdata_in;
  logic       comdata_out;
  logic       rx_start = 1'b0;
  logic       tx_start = 1'b0;
  logic [3:0] rx_len = 4'd0;
  logic [3:0] tx_len = 4'd0;
  logic [7:0] tx_data = 8'd0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_done;
  logic       busy;
  logic       err;

  always #5 clk_sys = ~clk_sys;

  ipc_comlink #(
    .PULSE_LEN(P),
    .SETTLE   (S),
    .TIMEOUT  (T)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .comctrl    (comctrl),
    .comdata_in (comdata_in),
    .comdata_out(comdata_out),
    .rx_start   (rx_start),
    .tx_start   (tx_start),
    .rx_len     (rx_len),
    .tx_len     (tx_len),
    .tx_data    (tx_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_done    (tx_done),
    .busy       (busy),
    .err        (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- host (ZX8302) comdata shift register ----------------
  logic [3:0] host_reg = 4'hF;
  logic [3:0] host_nib = 4'hF;
  logic       host_load = 1'b0;
  logic       ctl_prev = 1'b1;
  int         falls = 0;

  always @(posedge clk_sys) begin
    if (host_load) host_reg <= host_nib;
    else if (ctl_prev && !comctrl) host_reg <= {1'b1, host_reg[3:1]};
    if (ctl_prev && !comctrl) falls <= falls + 1;
    ctl_prev <= comctrl;
  end

  assign comdata_in = host_reg[0];

  // ---------------- reference model ----------------
  localparam int MIdle = 0;
  localparam int MWait = 1;
  localparam int MBit  = 2;
  localparam int MHold = 3;

  int         m_act = MIdle;
  int         m_t = 0;
  int         m_w = 0;
  int         m_left = 0;
  logic       m_tx = 1'b0;
  logic [7:0] m_data = 8'd0;
  int         m_shift = 0;
  logic       m_s1 = 1'b1;
  logic       m_cd = 1'b1;
  logic       cd_now;
  logic       e_comctrl = 1'b1;
  logic       e_cdo = 1'b1;
  logic       e_busy = 1'b0;
  logic [7:0] e_rx_data = 8'd0;
  logic       e_rx_valid = 1'b0;
  logic       e_tx_done = 1'b0;
  logic       e_err = 1'b0;

  function automatic int nbits(input logic [3:0] l);
    return ((l == 4'd0) || (l > 4'd8)) ? 8 : int'(l);
  endfunction

  function automatic logic bit_of(input logic [7:0] d, input int n);
    return d[n - 1];
  endfunction

  // Bit timeline: t=1 is the first comctrl-low cycle after the start is seen;
  // D is taken at t=P+S and E at t=2(P+S).
  initial begin
    forever begin
      @(posedge clk_sys);
      cd_now = m_cd;
      m_cd = m_s1;
      m_s1 = comdata_in;
      e_rx_valid = 1'b0;
      e_tx_done = 1'b0;
      e_err = 1'b0;
      if (reset) begin
        m_act = MIdle;
        e_cdo = 1'b1;
        e_rx_data = 8'd0;
        m_cd = 1'b1;
        m_s1 = 1'b1;
      end else begin
        case (m_act)
          MIdle: begin
            if (rx_start) begin
              m_act = MWait; m_tx = 1'b0; m_left = nbits(rx_len); m_shift = 0; m_w = 0;
            end else if (tx_start) begin
              m_act = MWait; m_tx = 1'b1; m_left = nbits(tx_len); m_data = tx_data; m_w = 0;
              e_cdo = bit_of(m_data, m_left);
            end
          end
          MWait: begin
            if (cd_now == 1'b0) begin
              m_act = MBit; m_t = 1;
            end else if (m_w == T - 1) begin
              e_err = 1'b1; e_cdo = 1'b1; m_act = MIdle;
            end else begin
              m_w++;
            end
          end
          MBit: begin
            if (m_t == P + S && !m_tx) m_shift = ((m_shift * 2) + int'(cd_now)) % 256;
            if (m_t == 2 * (P + S)) begin
              if (cd_now == 1'b0) begin
                e_err = 1'b1; e_cdo = 1'b1; m_act = MIdle;
              end else begin
                m_left--; m_w = 0;
                if (m_tx) m_act = MHold;
                else if (m_left == 0) begin
                  e_rx_valid = 1'b1; e_rx_data = 8'(m_shift); m_act = MIdle;
                end else m_act = MWait;
              end
            end else begin
              m_t++;
            end
          end
          default: begin
            if (cd_now == 1'b0) begin
              if (m_left > 0) begin
                m_act = MBit; m_t = 1; e_cdo = bit_of(m_data, m_left);
              end else begin
                e_tx_done = 1'b1; e_cdo = 1'b1; m_act = MIdle;
              end
            end else if (m_w == T - 1) begin
              e_cdo = 1'b1; m_act = MIdle;
              if (m_left > 0) e_err = 1'b1;
              else e_tx_done = 1'b1;
            end else begin
              m_w++;
            end
          end
        endcase
      end
      e_busy = (m_act != MIdle);
      e_comctrl = !((m_act == MBit) &&
                    (((m_t >= 1) && (m_t <= P)) || ((m_t >= P + S + 1) && (m_t <= 2 * P + S))));
    end
  end

  // ---------------- compare process ----------------
  logic       chk_en = 1'b0;
  int         n_rxv = 0;
  int         n_txd = 0;
  int         n_err = 0;
  logic [7:0] last_rx = 8'd0;
  time        t_err = 0;
  logic       busy_at_err = 1'b1;

  initial begin
    forever begin
      @(negedge clk_sys);
      if (chk_en) begin
        check1("comctrl", comctrl, e_comctrl);
        check1("comdata_out", comdata_out, e_cdo);
        check1("busy", busy, e_busy);
        check1("rx_valid", rx_valid, e_rx_valid);
        check1("tx_done", tx_done, e_tx_done);
        check1("err", err, e_err);
        check8("rx_data", rx_data, e_rx_data);
        if (rx_valid) begin n_rxv++; last_rx = rx_data; end
        if (tx_done) n_txd++;
        if (err) begin n_err++; t_err = $time; busy_at_err = busy; end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_nib(input logic [3:0] nib);
    host_nib = nib;
    host_load = 1'b1;
    @(negedge clk_sys);
    host_load = 1'b0;
  endtask

  task automatic wait_falls(input int target, input string nm);
    int c = 0;
    while (falls < target && c < 500) begin @(negedge clk_sys); c++; end
    if (falls < target) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: comctrl edges %0d, required %0d before bound", nm, falls, target);
    end
  endtask

  task automatic wait_high(input string nm);
    int c = 0;
    while (!comctrl && c < 500) begin @(negedge clk_sys); c++; end
    if (!comctrl) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: comctrl stuck low, got 0 required 1", nm);
    end
  endtask

  // One host nibble {1, E, D, S=0}; returns once the IPC has taken E.
  task automatic host_bit(input logic d, input logic e, input string nm);
    int f0;
    f0 = falls;
    load_nib({1'b1, e, d, 1'b0});
    wait_falls(f0 + 2, nm);
    wait_high(nm);
    repeat (S + 4) @(negedge clk_sys);
  endtask

  task automatic wait_count(input string nm, input int which, input int target, input int bound);
    int c = 0;
    int v;
    v = (which == 0) ? n_rxv : (which == 1) ? n_txd : n_err;
    while (v < target && c < bound) begin
      @(negedge clk_sys); c++;
      v = (which == 0) ? n_rxv : (which == 1) ? n_txd : n_err;
    end
    if (v < target) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: event count %0d, required %0d before bound", nm, v, target);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [7:0] dpat;
    logic [2:0] txexp;
    int f_start, rxv0, txd0, err0;
    time t0;

    repeat (2) @(negedge clk_sys);
    chk_en = 1'b1;
    check1("rst_comctrl", comctrl, 1'b1);
    check1("rst_comdata_out", comdata_out, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check8("rst_rx_data", rx_data, 8'h00);
    check1("rst_pulses", rx_valid | tx_done | err, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);

    // 8-bit receive of 0xB3
    f_start = falls; rxv0 = n_rxv; err0 = n_err;
    rx_len = 4'd8; rx_start = 1'b1;
    @(negedge clk_sys);
    rx_start = 1'b0;
    dpat = 8'hB3;
    for (int i = 7; i >= 0; i--) host_bit(dpat[i], 1'b1, "rx8_bit");
    check_int("rx8_falls", falls - f_start, 16);
    check_int("rx8_valid_count", n_rxv - rxv0, 1);
    check8("rx8_data", last_rx, 8'hB3);
    check_int("rx8_err_count", n_err - err0, 0);

    // 3-bit transmit of 0x05: host should see 1,0,1
    load_nib(4'hF);
    txd0 = n_txd;
    tx_len = 4'd3; tx_data = 8'h05; tx_start = 1'b1;
    @(negedge clk_sys);
    tx_start = 1'b0;
    txexp = 3'b101;
    for (int i = 2; i >= 0; i--) begin
      host_bit(1'b1, 1'b1, "tx3_bit");
      check1("tx3_hold_bit", comdata_out, txexp[i]);
    end
    wait_count("tx3_done", 1, txd0 + 1, T + 50);
    @(negedge clk_sys);
    check_int("tx3_done_count", n_txd - txd0, 1);
    check1("tx3_idle_high", comdata_out, 1'b1);

    // start-bit timeout
    load_nib(4'hF);
    repeat (3) @(negedge clk_sys);
    f_start = falls; err0 = n_err;
    rx_len = 4'd4; rx_start = 1'b1;
    @(negedge clk_sys);
    rx_start = 1'b0;
    t0 = $time;
    wait_count("timeout_err", 2, err0 + 1, T + 50);
    check_int("timeout_cycles", int'((t_err - t0) / 10), T);
    check_int("timeout_falls", falls - f_start, 0);

    // stop bit forced low on the second bit
    rxv0 = n_rxv; err0 = n_err;
    rx_len = 4'd4; rx_start = 1'b1;
    @(negedge clk_sys);
    rx_start = 1'b0;
    host_bit(1'b1, 1'b1, "ebad_bit0");
    host_bit(1'b0, 1'b0, "ebad_bit1");
    check_int("ebad_err_count", n_err - err0, 1);
    check_int("ebad_rx_valid", n_rxv - rxv0, 0);
    check1("ebad_busy_at_err", busy_at_err, 1'b0);
    load_nib(4'hF);
    repeat (4) @(negedge clk_sys);

    // simultaneous starts, rx_len=0 means 8 bits; transmit is dropped
    rxv0 = n_rxv; txd0 = n_txd;
    rx_len = 4'd0; tx_len = 4'd3; tx_data = 8'hFF;
    rx_start = 1'b1; tx_start = 1'b1;
    @(negedge clk_sys);
    rx_start = 1'b0; tx_start = 1'b0;
    dpat = 8'h5A;
    for (int i = 7; i >= 0; i--) host_bit(dpat[i], 1'b1, "both_bit");
    repeat (T + 20) @(negedge clk_sys);
    check_int("both_rx_valid", n_rxv - rxv0, 1);
    check8("both_rx_data", last_rx, 8'h5A);
    check_int("both_no_tx_done", n_txd - txd0, 0);

    // reset during the first comctrl low pulse
    f_start = falls;
    rx_len = 4'd2; rx_start = 1'b1;
    @(negedge clk_sys);
    rx_start = 1'b0;
    load_nib(4'b1110);
    wait_falls(f_start + 1, "rst_low1");
    check1("rst_low1_in_pulse", comctrl, 1'b0);
    reset = 1'b1;
    @(negedge clk_sys);
    check1("rst_low1_comctrl", comctrl, 1'b1);
    check1("rst_low1_busy", busy, 1'b0);
    reset = 1'b0;
    load_nib(4'hF);
    repeat (3) @(negedge clk_sys);
    rxv0 = n_rxv;
    rx_len = 4'd2; rx_start = 1'b1;
    @(negedge clk_sys);
    rx_start = 1'b0;
    host_bit(1'b1, 1'b1, "after_rst_bit");
    host_bit(1'b0, 1'b1, "after_rst_bit");
    check_int("after_rst_valid", n_rxv - rxv0, 1);
    check8("after_rst_data", last_rx, 8'h02);

    repeat (5) @(negedge clk_sys);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
